ppi_deframer: RTL and testbench

Receive-side checker/demultiplexer for the CPLD-to-Blackfin PPI stream. It consumes the 16-bit PPI word stream and frame sync, discards the protocol's lost first sample, and splits words into paired channel-1/channel-2 12-bit samples. It verifies the 3-bit rolling tag and the every-256-word node marker, and checks frame length. It is used as an in-CPLD loopback monitor and as the DSP-side reference model.

---
 rtl/ppi_pkg.sv | 21 ++
 rtl/ppi_deframer_if.sv | 14 +
 rtl/ppi_tag_checker.sv | 86 ++++++++
 rtl/ppi_deframer.sv | 167 ++++++++++++++++
 tb/tb_ppi_deframer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppi_pkg.sv
// ppi_pkg: shared definitions for the PPI receive-side deframer.
//   Word layout: [15:13] rolling tag, [12] node marker, [11:0] sample.
//   Also holds the marker period, default frame length and the FSM state type.
package ppi_pkg;

  localparam int TAG_MSB             = 15;
  localparam int TAG_LSB             = 13;
  localparam int MARKER_BIT          = 12;
  localparam int SAMPLE_MSB          = 11;
  localparam int TAG_W               = 3;
  localparam int MARKER_PERIOD       = 256;
  localparam int IDX_W               = $clog2(MARKER_PERIOD);
  localparam int FRAME_WORDS_DEFAULT = 2560;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2
  } ppi_state_e;

endpackage

// File: rtl/ppi_deframer_if.sv
// ppi_deframer_if: the raw PPI word stream as seen by the deframer.
//   ppi_data : 16-bit PPI word (tag / marker / sample)
//   ppi_fs   : frame sync, active high
// The master modport drives the stream (CPLD side or bench), the slave
// modport consumes it (deframer).
interface ppi_deframer_if;

  logic [15:0] ppi_data;
  logic        ppi_fs;

  modport master (output ppi_data, output ppi_fs);
  modport slave  (input  ppi_data, input  ppi_fs);

endinterface

// File: rtl/ppi_tag_checker.sv
// ppi_tag_checker: rolling-tag continuity and node-marker phase checker.
//   clk, rst_n  : clock, asynchronous active-low reset
//   accept      : a word is consumed this cycle
//   frame_clr   : the frame is being abandoned; forget tag history and lock
//   tag, marker : fields of the current word
//   seq_err     : registered pulse, tag discontinuity (or lock word with tag != 0)
//   marker_err  : registered pulse, marker bit disagrees with the locked phase
//   locked      : marker phase acquired in the current frame
//   err_hit     : combinational, an error pulse will be raised at this edge
module ppi_tag_checker
  import ppi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             frame_clr,
  input  logic [TAG_W-1:0] tag,
  input  logic             marker,
  output logic             seq_err,
  output logic             marker_err,
  output logic             locked,
  output logic             err_hit
);

  logic [TAG_W-1:0] exp_tag;
  logic             have_tag;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             seq_err_d;
  logic             marker_err_d;
  logic             lock_now;

  // Error decisions for the current word. idx holds the position of the
  // previous word, so idx_next is where this word sits in the marker period.
  always_comb begin
    seq_err_d    = 1'b0;
    marker_err_d = 1'b0;
    lock_now     = 1'b0;
    idx_next     = idx + 1'b1;
    if (accept) begin
      if (have_tag && (tag != exp_tag)) seq_err_d = 1'b1;
      if (!locked) begin
        if (marker) begin
          lock_now = 1'b1;
          if (tag != '0) seq_err_d = 1'b1;
        end
      end else if (marker != (idx_next == '0)) begin
        marker_err_d = 1'b1;
      end
    end
  end

  assign err_hit = seq_err_d | marker_err_d;

  // Expected tag always resyncs to the word just seen, so one bad tag
  // produces a single pulse rather than a run of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err    <= 1'b0;
      marker_err <= 1'b0;
      locked     <= 1'b0;
      have_tag   <= 1'b0;
      exp_tag    <= '0;
      idx        <= '0;
    end else begin
      seq_err    <= seq_err_d;
      marker_err <= marker_err_d;
      if (frame_clr) begin
        locked   <= 1'b0;
        have_tag <= 1'b0;
        exp_tag  <= '0;
        idx      <= '0;
      end else if (accept) begin
        have_tag <= 1'b1;
        exp_tag  <= tag + 1'b1;
        if (lock_now) begin
          locked <= 1'b1;
          idx    <= '0;
        end else if (locked) begin
          idx <= idx_next;
        end
      end
    end
  end

endmodule

// File: rtl/ppi_deframer.sv
// ppi_deframer: receive-side checker/demultiplexer for the PPI stream.
//   PPI_CLK, RST_N       : word clock, asynchronous active-low reset
//   enable               : 1 = monitor the stream, 0 = hold in IDLE
//   ppi (slave)          : ppi_data / ppi_fs word stream
//   err_clr              : synchronous clear of err_count
//   ch1_data, ch2_data   : last emitted sample pair
//   pair_valid           : pulse, a new pair is on ch1_data/ch2_data
//   seq_err, marker_err  : error pulses from the tag checker
//   locked               : marker phase acquired in the current frame
//   frame_done           : pulse, frame sync fell while running
//   frame_len_ok         : with frame_done, frame length matched FRAME_WORDS
//   err_count            : saturating count of cycles with any error
// Optional statistics (err_count, err_clr, length check) are built only when
// PPI_DEFRAMER_STATS_EN is defined; otherwise err_count=0, frame_len_ok=1.
//
// The word that arrives while in IDLE with fs high is the protocol's lost
// sample: it is counted in the frame length but never processed. Every word
// presented in SKIP or RUN with fs high is accepted; SKIP only marks the
// first accepted word of the frame.
module ppi_deframer
  import ppi_pkg::*;
#(
  parameter int DATA_W      = 12,
  parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int ERR_CNT_W   = 8,
  parameter int LEN_W       = 12
) (
  input  logic                 PPI_CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  ppi_deframer_if.slave        ppi,
  input  logic                 err_clr,
  output logic [DATA_W-1:0]    ch1_data,
  output logic [DATA_W-1:0]    ch2_data,
  output logic                 pair_valid,
  output logic                 seq_err,
  output logic                 marker_err,
  output logic                 locked,
  output logic                 frame_done,
  output logic                 frame_len_ok,
  output logic [ERR_CNT_W-1:0] err_count
);

  ppi_state_e        state;
  ppi_state_e        state_next;
  logic              accept;
  logic              frame_end;
  logic              start;
  logic              leave;
  logic [TAG_W-1:0]  tag;
  logic              marker;
  logic              is_ch2;
  logic [DATA_W-1:0] sample;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic              err_hit;
  logic              len_match;

  assign tag       = ppi.ppi_data[TAG_MSB:TAG_LSB];
  assign marker    = ppi.ppi_data[MARKER_BIT];
  assign sample    = ppi.ppi_data[SAMPLE_MSB -: DATA_W];
  assign is_ch2    = tag[0];
  assign len_match = (len == LEN_W'(FRAME_WORDS));

  // State register.
  always_ff @(posedge PPI_CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle strobes; losing fs or enable always ends the frame.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (enable && ppi.ppi_fs) state_next = SKIP;
      SKIP, RUN: begin
        if (!enable || !ppi.ppi_fs) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
          accept     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    frame_end = (state == RUN) && enable && !ppi.ppi_fs;
    start     = (state == IDLE) && (state_next == SKIP);
    leave     = (state != IDLE) && (state_next == IDLE);
  end

  ppi_tag_checker u_tag_checker (
    .clk        (PPI_CLK),
    .rst_n      (RST_N),
    .accept     (accept),
    .frame_clr  (leave),
    .tag        (tag),
    .marker     (marker),
    .seq_err    (seq_err),
    .marker_err (marker_err),
    .locked     (locked),
    .err_hit    (err_hit)
  );

  // Frame length and channel pairing. A ch2 word pairs only with the ch1
  // word accepted just before it; anything else empties the holding register.
  always_ff @(posedge PPI_CLK or negedge RST_N) begin
    if (!RST_N) begin
      len        <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      ch1_data   <= '0;
      ch2_data   <= '0;
      pair_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      frame_done <= frame_end;
      if (start) begin
        len <= LEN_W'(1);
      end else if (leave) begin
        len        <= '0;
        hold       <= '0;
        hold_valid <= 1'b0;
      end else if (accept) begin
        if (len != '1) len <= len + 1'b1;
        if (!is_ch2) begin
          hold       <= sample;
          hold_valid <= 1'b1;
        end else begin
          hold_valid <= 1'b0;
          if (hold_valid) begin
            ch1_data   <= hold;
            ch2_data   <= sample;
            pair_valid <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PPI_DEFRAMER_STATS_EN
  // Error cycle counter; clear wins over a simultaneous error.
  always_ff @(posedge PPI_CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (err_hit && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  // Length verdict accompanies the frame_done pulse only.
  always_ff @(posedge PPI_CLK or negedge RST_N) begin
    if (!RST_N) frame_len_ok <= 1'b0;
    else        frame_len_ok <= frame_end && len_match;
  end
`else
  logic unused_stats;
  assign unused_stats = ^{err_clr, err_hit, len_match};
  assign err_count    = '0;
  assign frame_len_ok = 1'b1;
`endif

endmodule

// File: tb/tb_ppi_deframer.sv
// tb_ppi_deframer: self-checking bench for ppi_deframer.
// A frame-level reference model (word counts, lock position, previous word)
// predicts every output each cycle; directed frames pin pulse totals with
// hand-computed literals, then randomized frames exercise corner mixes.
module tb_ppi_deframer;
  import ppi_pkg::*;

`ifdef PPI_DEFRAMER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int FW = 2560;

  logic        PPI_CLK = 1'b0;
  logic        RST_N   = 1'b0;
  logic        enable  = 1'b0;
  logic        err_clr = 1'b0;
  logic [11:0] ch1_data, ch2_data;
  logic        pair_valid, seq_err, marker_err, locked, frame_done, frame_len_ok;
  logic [7:0]  err_count;

  ppi_deframer_if ppi_bus ();

  ppi_deframer dut (
    .PPI_CLK      (PPI_CLK),
    .RST_N        (RST_N),
    .enable       (enable),
    .ppi          (ppi_bus),
    .err_clr      (err_clr),
    .ch1_data     (ch1_data),
    .ch2_data     (ch2_data),
    .pair_valid   (pair_valid),
    .seq_err      (seq_err),
    .marker_err   (marker_err),
    .locked       (locked),
    .frame_done   (frame_done),
    .frame_len_ok (frame_len_ok),
    .err_count    (err_count)
  );

  always #5 PPI_CLK = ~PPI_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: words seen with fs high in this frame, position of
  // the lock word, and the previously accepted word.
  int          nwords = 0, lock_pos = -1, prev_tag = 0, e_cnt = 0;
  int          m_k, m_tag;
  bit          m_mk;
  logic [11:0] m_s;
  bit          prev_ch1 = 1'b0;
  logic [11:0] prev_sample = '0, e_ch1 = '0, e_ch2 = '0;
  bit          e_pair = 0, e_seq = 0, e_mark = 0, e_locked = 0, e_done = 0;
  bit          e_lenok = !STATS;

  always @(posedge PPI_CLK or negedge RST_N) begin
    if (!RST_N) begin
      nwords = 0; lock_pos = -1; prev_ch1 = 0; e_cnt = 0;
      e_ch1 = '0; e_ch2 = '0;
      e_pair = 0; e_seq = 0; e_mark = 0; e_locked = 0; e_done = 0;
      e_lenok = !STATS;
    end else begin
      e_pair = 0; e_seq = 0; e_mark = 0; e_done = 0; e_lenok = !STATS;
      if (enable && ppi_bus.ppi_fs) begin
        nwords++;
        if (nwords >= 2) begin
          m_k   = nwords - 2;
          m_tag = int'(ppi_bus.ppi_data[15:13]);
          m_mk  = ppi_bus.ppi_data[12];
          m_s   = ppi_bus.ppi_data[11:0];
          if (m_k > 0 && m_tag != (prev_tag + 1) % 8) e_seq = 1;
          if (lock_pos < 0) begin
            if (m_mk) begin
              lock_pos = m_k;
              if (m_tag != 0) e_seq = 1;
            end
          end else if (m_mk != (((m_k - lock_pos) % 256) == 0)) begin
            e_mark = 1;
          end
          if ((m_tag % 2 == 1) && prev_ch1) begin
            e_ch1 = prev_sample; e_ch2 = m_s; e_pair = 1;
          end
          prev_ch1 = (m_tag % 2 == 0); prev_sample = m_s; prev_tag = m_tag;
        end
      end else begin
        if (enable && nwords >= 2) begin
          e_done = 1;
          if (STATS) e_lenok = (((nwords > 4095) ? 4095 : nwords) == FW);
        end
        nwords = 0; lock_pos = -1; prev_ch1 = 0;
      end
      e_locked = (lock_pos >= 0);
      if (STATS) begin
        if (err_clr) e_cnt = 0;
        else if ((e_seq || e_mark) && e_cnt < 255) e_cnt++;
      end
    end
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("ch1_data", 32'(ch1_data), 32'(e_ch1));
    checkVal("ch2_data", 32'(ch2_data), 32'(e_ch2));
    checkVal("pair_valid", 32'(pair_valid), 32'(e_pair));
    checkVal("seq_err", 32'(seq_err), 32'(e_seq));
    checkVal("marker_err", 32'(marker_err), 32'(e_mark));
    checkVal("locked", 32'(locked), 32'(e_locked));
    checkVal("frame_done", 32'(frame_done), 32'(e_done));
    checkVal("frame_len_ok", 32'(frame_len_ok), 32'(e_lenok));
    checkVal("err_count", 32'(err_count), 32'(e_cnt));
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge PPI_CLK) checkOutput();

  // Pulse tallies used by the directed literal checks.
  int pair_cnt = 0, seq_cnt = 0, mark_cnt = 0, done_cnt = 0;
  logic last_lenok = 1'b0;
  always @(negedge PPI_CLK) begin
    if (pair_valid) pair_cnt++;
    if (seq_err) seq_cnt++;
    if (marker_err) mark_cnt++;
    if (frame_done) begin
      done_cnt++;
      last_lenok = frame_len_ok;
    end
  end

  task automatic applyStimulus(input bit en, input bit fs, input logic [15:0] word, input bit clr);
    @(negedge PPI_CLK);
    enable = en; ppi_bus.ppi_fs = fs; ppi_bus.ppi_data = word; err_clr = clr;
  endtask

  function automatic logic [15:0] makeWord(input int tag, input bit mk);
    logic [2:0] t;
    t = 3'(tag);
    return {t, mk, 12'($urandom_range(0, 4095))};
  endfunction

  task automatic settle();
    repeat (2) applyStimulus(1, 0, 16'h0000, 0);
    #1;
  endtask

  task automatic clearTallies();
    pair_cnt = 0; seq_cnt = 0; mark_cnt = 0; done_cnt = 0; last_lenok = 1'b0;
  endtask

  // Word 0 is the lost sample; accepted word k carries tag (k+1)%8 (shifted by
  // one after jump_at) and a marker whenever (k+1) is a multiple of 256.
  task automatic sendFrame(input int nw, input int jump_at, input int extra_mk, input int drop_mk);
    int tag, k;
    bit mk;
    applyStimulus(1, 1, makeWord(0, 0), 0);
    for (int i = 1; i < nw; i++) begin
      k   = i - 1;
      tag = (jump_at >= 0 && k >= jump_at) ? (k + 2) % 8 : (k + 1) % 8;
      mk  = ((k + 1) % 256 == 0);
      if (k == extra_mk) mk = 1;
      if (k == drop_mk) mk = 0;
      applyStimulus(1, 1, makeWord(tag, mk), 0);
    end
  endtask

  task automatic sendRandomFrame(input int nw);
    int t0, ph, tag, k;
    bit mk, en;
    t0 = $urandom_range(0, 7);
    ph = $urandom_range(0, 255);
    applyStimulus(1, 1, makeWord(0, 0), 0);
    for (int i = 1; i < nw; i++) begin
      k   = i - 1;
      tag = (k + t0) % 8;
      if ($urandom_range(0, 15) == 0) tag = $urandom_range(0, 7);
      mk = ((k + ph) % 256 == 0);
      if ($urandom_range(0, 31) == 0) mk = !mk;
      en = ($urandom_range(0, 399) != 0);
      applyStimulus(en, 1, makeWord(tag, mk), $urandom_range(0, 49) == 0);
    end
    repeat ($urandom_range(1, 4)) applyStimulus(1'($urandom_range(0, 1)), 0, makeWord(0, 0), 0);
  endtask

  initial begin
    ppi_bus.ppi_fs = 1'b0;
    ppi_bus.ppi_data = '0;
    repeat (3) @(negedge PPI_CLK);
    #2 RST_N = 1'b1;
    #1;
    checkVal("reset_ch1", 32'(ch1_data), 0);
    checkVal("reset_pair_valid", 32'(pair_valid), 0);
    checkVal("reset_locked", 32'(locked), 0);
    checkVal("reset_err_count", 32'(err_count), 0);

    $display("[TB] clean 2560-word frame");
    clearTallies();
    sendFrame(2560, -1, -1, -1);
    @(posedge PPI_CLK); #1;
    checkVal("A_locked", 32'(locked), 1);
    settle();
    checkVal("A_pairs", pair_cnt, 1279);
    checkVal("A_seq", seq_cnt, 0);
    checkVal("A_mark", mark_cnt, 0);
    checkVal("A_done", done_cnt, 1);
    checkVal("A_lenok", 32'(last_lenok), 1);

    $display("[TB] tag jump 3->5");
    applyStimulus(0, 0, 16'h0000, 1);
    settle();
    clearTallies();
    sendFrame(2560, 299, -1, -1);
    settle();
    checkVal("B_seq", seq_cnt, 1);
    checkVal("B_pairs", pair_cnt, 1278);
    checkVal("B_err_count", 32'(err_count), STATS ? 1 : 0);

    $display("[TB] marker extra at idx 17, missing at idx 0");
    clearTallies();
    sendFrame(2560, -1, 272, 511);
    settle();
    checkVal("C_mark", mark_cnt, 2);
    checkVal("C_seq", seq_cnt, 0);
    checkVal("C_pairs", pair_cnt, 1279);
    checkVal("C_err_count", 32'(err_count), STATS ? 3 : 0);

    $display("[TB] short frame ending on a ch1 word");
    clearTallies();
    sendFrame(2001, -1, -1, -1);
    settle();
    checkVal("D_pairs", pair_cnt, 999);
    checkVal("D_done", done_cnt, 1);
    checkVal("D_lenok", 32'(last_lenok), STATS ? 0 : 1);
    clearTallies();
    sendFrame(12, -1, -1, -1);
    settle();
    checkVal("D2_pairs", pair_cnt, 5);

    $display("[TB] enable dropped mid-frame");
    clearTallies();
    sendFrame(600, -1, -1, -1);
    repeat (3) applyStimulus(0, 1, makeWord(0, 0), 0);
    repeat (2) applyStimulus(0, 0, makeWord(0, 0), 0);
    #1;
    checkVal("E_done", done_cnt, 0);
    checkVal("E_locked", 32'(locked), 0);

    $display("[TB] reset mid-frame");
    sendFrame(300, 100, -1, -1);
    @(negedge PPI_CLK);
    #2 RST_N = 1'b0;
    #1;
    checkVal("F_ch1", 32'(ch1_data), 0);
    checkVal("F_ch2", 32'(ch2_data), 0);
    checkVal("F_locked", 32'(locked), 0);
    checkVal("F_seq", 32'(seq_err), 0);
    checkVal("F_err_count", 32'(err_count), 0);
    checkVal("F_lenok", 32'(frame_len_ok), STATS ? 0 : 1);
    applyStimulus(0, 0, 16'h0000, 0);
    @(negedge PPI_CLK);
    #2 RST_N = 1'b1;
    settle();

    $display("[TB] error counter saturation and clear priority");
    sendFrame(2560, -1, -1, -1);
    settle();
    applyStimulus(1, 1, makeWord(0, 0), 0);
    for (int i = 0; i < 320; i++) applyStimulus(1, 1, makeWord(0, 0), 0);
    @(posedge PPI_CLK); #1;
    checkVal("G_saturated", 32'(err_count), STATS ? 255 : 0);
    applyStimulus(1, 1, makeWord(0, 0), 1);
    @(posedge PPI_CLK); #1;
    checkVal("G_clear_wins", 32'(err_count), 0);
    applyStimulus(1, 1, makeWord(0, 0), 0);
    @(posedge PPI_CLK); #1;
    checkVal("G_count_after_clear", 32'(err_count), STATS ? 1 : 0);
    settle();

    $display("[TB] randomized frames");
    for (int f = 0; f < 14; f++) sendRandomFrame($urandom_range(3, 800));
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
